// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and defaults for the register-file write-back
//               front end.
//               - Default data/address widths, FIFO depth and starvation limit
//               - ZERO_REG : architectural zero register (writes discarded)
//               - wb_entry_t : {addr, data} write record at default widths
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int WB_DATA_WIDTH   = 32;
    localparam int WB_ADDR_WIDTH   = 5;
    localparam int WB_FIFO_DEPTH   = 4;
    localparam int WB_STARVE_LIMIT = 8;

    localparam logic [WB_ADDR_WIDTH-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Circular buffer holding pending load write records.
//               Content-agnostic: the entry type is a type parameter so the
//               top level can size the record to its own widths.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_push/i_push_entry - write one entry (ignored when full)
//               i_pop            - drop the head entry (ignored when empty)
//               o_head           - current oldest entry
//               o_count          - number of valid entries
//               o_full/o_empty   - occupancy flags
//               o_entries        - raw storage, for associative lookup
//               o_wr_ptr         - next write slot (newest entry = o_wr_ptr-1)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = WB_FIFO_DEPTH,
    parameter type ENTRY_T = wb_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  ENTRY_T                   i_push_entry,
    input  logic                     i_pop,
    output ENTRY_T                   o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output ENTRY_T [DEPTH-1:0]       o_entries,
    output logic [$clog2(DEPTH)-1:0] o_wr_ptr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    ENTRY_T [DEPTH-1:0] r_mem;
    logic   [PTR_W-1:0] r_wr_ptr;
    logic   [PTR_W-1:0] r_rd_ptr;
    logic   [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    assign o_full    = (r_count == c_depth);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_entries = r_mem;
    assign o_wr_ptr  = r_wr_ptr;

    // Storage is not reset: occupancy is tracked by r_count alone, and every
    // consumer of the raw entries qualifies them against it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Pointer width equals log2(DEPTH), so increments wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback
// Description : Merges ALU results and buffered load results onto the single
//               register-file write port. ALU wins by default; a starvation
//               counter forces a load pop when the FIFO has been ignored for
//               STARVE_LIMIT cycles. A combinational bypass exposes writes
//               that are accepted but not yet committed.
// Ports       : clk, rst                         - clock, sync active-high reset
//               alu_valid/alu_ready/alu_addr/alu_data - ALU result handshake
//               mem_valid/mem_ready/mem_addr/mem_data - load result handshake
//               wr_en/wr_addr/wr_data            - registered write port
//               byp_addr/byp_hit/byp_data        - pending-write lookup
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH   = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH   = WB_ADDR_WIDTH,
    parameter int FIFO_DEPTH   = WB_FIFO_DEPTH,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] byp_addr,
    output logic                  byp_hit,
    output logic [DATA_WIDTH-1:0] byp_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [ADDR_WIDTH-1:0] c_zero_addr    = ADDR_WIDTH'(ZERO_REG);
    localparam logic [STV_W-1:0]      c_starve_limit = STV_W'(STARVE_LIMIT);

    // Write record sized to this instance's widths.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                  w_push_entry;
    entry_t                  w_head;
    entry_t [FIFO_DEPTH-1:0] w_entries;
    logic   [CNT_W-1:0]      w_count;
    logic   [PTR_W-1:0]      w_wr_ptr;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_alu_wr;
    logic   [PTR_W-1:0]      w_idx;

    logic                    r_force;
    logic   [STV_W-1:0]      r_starve_cnt;
    logic                    r_wr_en;
    logic   [ADDR_WIDTH-1:0] r_wr_addr;
    logic   [DATA_WIDTH-1:0] r_wr_data;

    // ------------------------------------------------------------------
    // Handshakes. A full FIFO refuses loads even if it pops this cycle,
    // keeping mem_ready free of any path from the arbitration decision.
    // ------------------------------------------------------------------
    assign mem_ready = !rst && !w_full;
    assign alu_ready = !rst && !r_force;

    // Loads to the zero register are accepted and dropped.
    assign w_push       = mem_valid && mem_ready && (mem_addr != c_zero_addr);
    assign w_push_entry = '{addr: mem_addr, data: mem_data};

    // ALU owns the port only when it carries a real write; an ALU write to
    // the zero register leaves the port free for a load pop. While force is
    // set alu_ready is low, so w_alu_wr is low and the head is popped.
    assign w_alu_wr = alu_valid && alu_ready && (alu_addr != c_zero_addr);
    assign w_pop    = !w_empty && !w_alu_wr;

    wb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_entries    (w_entries),
        .o_wr_ptr     (w_wr_ptr)
    );

    // ------------------------------------------------------------------
    // Starvation tracking. The counter saturates at the limit; force is
    // raised one edge after the limit is observed and dropped by the pop
    // it causes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_force      <= 1'b0;
        end else begin
            if (w_empty || w_pop) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != c_starve_limit) begin
                r_starve_cnt <= r_starve_cnt + STV_W'(1);
            end

            if (r_force && w_pop) begin
                r_force <= 1'b0;
            end else if ((r_starve_cnt == c_starve_limit) && !w_pop) begin
                r_force <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register. Address/data hold when idle; only wr_en drops.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_pop) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_head.addr;
            r_wr_data <= w_head.data;
        end else if (w_alu_wr) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= alu_addr;
            r_wr_data <= alu_data;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

    // ------------------------------------------------------------------
    // Bypass. Later assignments override earlier ones, so the output
    // register is considered first (oldest), then FIFO slots from oldest
    // to newest; the newest matching pending value wins.
    // ------------------------------------------------------------------
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        w_idx    = '0;

        if (r_wr_en && (r_wr_addr == byp_addr)) begin
            byp_hit  = 1'b1;
            byp_data = r_wr_data;
        end

        // k is age from the newest entry: k = 0 is the slot just written.
        for (int k = FIFO_DEPTH - 1; k >= 0; k--) begin
            w_idx = w_wr_ptr - PTR_W'(1) - PTR_W'(k);
            if ((CNT_W'(k) < w_count) && (w_entries[w_idx].addr == byp_addr)) begin
                byp_hit  = 1'b1;
                byp_data = w_entries[w_idx].data;
            end
        end

        if (byp_addr == c_zero_addr) begin
            byp_hit  = 1'b0;
            byp_data = '0;
        end
    end

endmodule : regfile_writeback
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_writeback
// Description : Directed self-checking bench for regfile_writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [AW-1:0] alu_addr = '0;
    logic [DW-1:0] alu_data = '0;
    logic          mem_valid = 1'b0;
    logic          mem_ready;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_data = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] byp_addr = '0;
    logic          byp_hit;
    logic [DW-1:0] byp_data;

    int n_checks = 0;
    int n_errors = 0;

    regfile_writeback #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .byp_addr  (byp_addr),
        .byp_hit   (byp_hit),
        .byp_data  (byp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and step clear of it before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_alu_ready", 64'(alu_ready), 64'd0);
        check("rst_mem_ready", 64'(mem_ready), 64'd0);
        check("rst_wr_en",     64'(wr_en),     64'd0);
        check("rst_wr_addr",   64'(wr_addr),   64'd0);
        check("rst_wr_data",   64'(wr_data),   64'd0);
        check("rst_count",     64'(dut.w_count), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_alu_ready", 64'(alu_ready), 64'd1);
        check("post_rst_mem_ready", 64'(mem_ready), 64'd1);

        // ---------------- single ALU write r3 = 0x2A ----------------
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h2A;
        tick();
        alu_valid = 1'b0; byp_addr = 5'd3;
        #1;
        check("alu_wr_en",    64'(wr_en),    64'd1);
        check("alu_wr_addr",  64'(wr_addr),  64'd3);
        check("alu_wr_data",  64'(wr_data),  64'h2A);
        check("alu_byp_hit",  64'(byp_hit),  64'd1);
        check("alu_byp_data", 64'(byp_data), 64'h2A);
        tick();
        check("alu_idle_wr_en",   64'(wr_en),   64'd0);
        check("alu_hold_addr",    64'(wr_addr), 64'd3);
        check("alu_hold_data",    64'(wr_data), 64'h2A);
        check("alu_idle_byp_hit", 64'(byp_hit), 64'd0);

        // ---------------- writes to x0 ----------------
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFF;
        mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'h77;
        #1;
        check("x0_alu_ready", 64'(alu_ready), 64'd1);
        check("x0_mem_ready", 64'(mem_ready), 64'd1);
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        check("x0_wr_en", 64'(wr_en), 64'd0);
        check("x0_count", 64'(dut.w_count), 64'd0);

        // ---------------- four loads, ALU idle ----------------
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1;
            mem_addr  = 5'(5 + i);
            mem_data  = 32'(32'h100 + 5 + i);
            tick();
            if (i == 0) begin
                check("ld_first_count", 64'(dut.w_count), 64'd1);
                check("ld_first_wr_en", 64'(wr_en), 64'd0);
            end else begin
                check("ld_wr_en",   64'(wr_en),   64'd1);
                check("ld_wr_addr", 64'(wr_addr), 64'(5 + i - 1));
                check("ld_wr_data", 64'(wr_data), 64'(32'h100 + 5 + i - 1));
            end
        end
        mem_valid = 1'b0;
        tick();
        check("ld_last_wr_addr", 64'(wr_addr), 64'd8);
        check("ld_last_wr_data", 64'(wr_data), 64'h108);
        check("ld_last_count",   64'(dut.w_count), 64'd0);
        tick();
        check("ld_done_wr_en", 64'(wr_en), 64'd0);

        // ---------------- starvation: ALU stream + load r9 ----------------
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'hA0;
        mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h55;
        tick();                         // load pushed, ALU written
        mem_valid = 1'b0;
        check("stv_count",   64'(dut.w_count), 64'd1);
        check("stv_wr_addr", 64'(wr_addr), 64'd1);
        // Eight edges build the counter to the limit, the ninth raises force.
        for (int s = 2; s <= 10; s++) begin
            tick();
            check("stv_alu_ready", 64'(alu_ready), (s == 10) ? 64'd0 : 64'd1);
            check("stv_alu_addr",  64'(wr_addr),   64'd1);
        end
        tick();
        check("stv_force_wr_en",   64'(wr_en),     64'd1);
        check("stv_force_wr_addr", 64'(wr_addr),   64'd9);
        check("stv_force_wr_data", 64'(wr_data),   64'h55);
        check("stv_alu_ready_back", 64'(alu_ready), 64'd1);
        check("stv_count_empty",   64'(dut.w_count), 64'd0);
        tick();
        check("stv_alu_resume_addr", 64'(wr_addr), 64'd1);
        check("stv_alu_resume_data", 64'(wr_data), 64'hA0);

        // ---------------- bypass with 3 pending loads ----------------
        alu_addr = 5'd2; alu_data = 32'hBB;
        mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h11;
        tick();
        mem_data = 32'h22;
        tick();
        mem_addr = 5'd7; mem_data = 32'h33;
        tick();
        mem_valid = 1'b0;
        check("byp_count", 64'(dut.w_count), 64'd3);
        byp_addr = 5'd4; #1;
        check("byp_r4_hit",  64'(byp_hit),  64'd1);
        check("byp_r4_data", 64'(byp_data), 64'h22);
        byp_addr = 5'd7; #1;
        check("byp_r7_data", 64'(byp_data), 64'h33);
        byp_addr = 5'd2; #1;
        check("byp_outreg_hit",  64'(byp_hit),  64'd1);
        check("byp_outreg_data", 64'(byp_data), 64'hBB);
        byp_addr = 5'd0; #1;
        check("byp_x0_hit",  64'(byp_hit),  64'd0);
        check("byp_x0_data", 64'(byp_data), 64'd0);
        byp_addr = 5'd5; #1;
        check("byp_miss_hit", 64'(byp_hit), 64'd0);

        // ---------------- reset with entries queued ----------------
        alu_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_alu_ready", 64'(alu_ready), 64'd0);
        check("mid_rst_mem_ready", 64'(mem_ready), 64'd0);
        tick();
        check("mid_rst_count",   64'(dut.w_count), 64'd0);
        check("mid_rst_wr_en",   64'(wr_en),   64'd0);
        check("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
        check("mid_rst_wr_data", 64'(wr_data), 64'd0);
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            byp_addr = 5'(a);
            #1;
            check("mid_rst_byp_hit", 64'(byp_hit), 64'd0);
        end

        // ---------------- fill the FIFO under ALU traffic ----------------
        alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'hCC;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1;
            mem_addr  = 5'(10 + i);
            mem_data  = 32'(32'h200 + i);
            tick();
        end
        mem_addr = 5'd14; mem_data = 32'h2FF;
        #1;
        check("full_count",     64'(dut.w_count), 64'd4);
        check("full_mem_ready", 64'(mem_ready), 64'd0);
        tick();
        check("full_no_push", 64'(dut.w_count), 64'd4);
        alu_valid = 1'b0; mem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_wr_addr", 64'(wr_addr), 64'(10 + i));
            check("drain_wr_data", 64'(wr_data), 64'(32'h200 + i));
        end
        check("drain_count",     64'(dut.w_count), 64'd0);
        check("drain_mem_ready", 64'(mem_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_regfile_writeback
`default_nettype wire
